cr16_mc_controller: RTL and testbench
=====================================

Name: cr16_mc_controller

Overview:
Multicycle control FSM for the CR16 datapath. It fetches each instruction through a request/ready memory handshake and decodes the latched IR. It then sequences the datapath select/enable strobes (pcen, ir_mux, regwrt, memtoreg, branch, jump, jal, im_mux, pc_mux, alusrcb, OP) across fetch, decode, execute, memory and writeback. It drives the control inputs of the ALU datapath and consumes its IR, flag and zero outputs.

Parameters:
MEM_WAIT_MAX, 15, maximum mem_ready wait cycles before err_timeout pulses (4-bit counter width).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
ir  input  16  latched instruction: [15:12] opcode, [11:8] rdest/cond, [7:4] ext, [3:0] rsrc/imm-low
flag  input  5  datapath flags {C,Z,F,N,L} = bits [4:0]
zero  input  1  datapath Z copy; used only for EQ/NE conditions
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  1 = store, 0 = read; valid only with mem_req
ir_mux  output  1  IR load enable
pcen  output  1  PC increment enable
branch  output  1  PC <= PC + 2*disp
jump  output  1  PC <= rd1
jal  output  1  link write (PC+1 into rdest)
regwrt  output  1  register file write enable
memtoreg  output  1  writeback select: 1 = memdata, 0 = ALU
im_mux  output  1  ALU B select: 1 = immediate
pc_mux  output  1  ALU A select: 1 = PC
alusrcb  output  2  00 reg, 01 sign-ext imm, 10 zero-ext imm, 11 imm<<8
OP  output  8  ALU opcode {ir[15:12], ir[7:4]}; for immediate forms {4'b0000, ir[15:12]}
state_dbg  output  4  current state encoding
err_timeout  output  1  one-cycle pulse when a memory wait exceeds MEM_WAIT_MAX
illegal  output  1  see Optional Feature

Behaviour:
- Reset: state = FETCH. All outputs 0; OP = 0; wait counter = 0. Reset mid-operation abandons any request; mem_req drops the following cycle.
- States: FETCH(0), DECODE(1), EXEC_R(2), EXEC_I(3), MEM_ADDR(4), MEM_RD(5), MEM_WR(6), LOAD_WB(7), BRANCH(8), JUMP(9), HALT(15).
- FETCH:
  - mem_req = 1, mem_we = 0; hold until mem_ready.
  - Cycle with mem_ready: ir_mux = 1, pcen = 1, next state DECODE.
- DECODE: one cycle, all strobes 0. Transitions:
  - opcode 0000 -> EXEC_R.
  - opcode in {0001,0010,0011,0101,1001,1011,1101,1111} -> EXEC_I.
  - opcode 0100: ext 0000 (LOAD) or 0100 (STOR) -> MEM_ADDR; ext 1100 (Jcond) or 1000 (JAL) -> JUMP.
  - opcode 1100 -> BRANCH.
  - Anything else is illegal.
- EXEC_R: alusrcb = 00, im_mux = 0, regwrt = 1 except ext 1011 (CMP, flags only). Next FETCH.
- EXEC_I:
  - alusrcb = 01 for ADDI/SUBI/CMPI; 10 for ANDI/ORI/XORI/MOVI; 11 for LUI (1111).
  - im_mux = 1; regwrt = 1 except CMPI (1011). Next FETCH.
- MEM_ADDR: address = rsrc register. Next MEM_RD (LOAD) or MEM_WR (STOR).
- MEM_RD / MEM_WR:
  - mem_req = 1; mem_we = 1 only in MEM_WR.
  - Hold until mem_ready. MEM_RD -> LOAD_WB; MEM_WR -> FETCH.
- LOAD_WB: regwrt = 1, memtoreg = 1. Next FETCH.
- BRANCH / JUMP condition, cond = ir[11:8]:
  - 0000 EQ: zero.
  - 0001 NE: !zero.
  - 0110 GT: N.
  - 0111 LE: !N.
  - 1100 LT: !N & !zero.
  - 1110 UC: 1.
  - Other codes: false.
- BRANCH: if true, branch = 1, pc_mux = 1, im_mux = 1, alusrcb = 01. Next FETCH.
- JUMP: Jcond true -> jump = 1. JAL -> jal = 1, regwrt = 1, jump = 1 unconditionally. Next FETCH.
- Memory wait counter:
  - Counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready = 0; saturates at MEM_WAIT_MAX.
  - err_timeout pulses once on reaching MEM_WAIT_MAX; the request stays asserted.
  - Counter clears on mem_ready or on any state change.
- mem_ready outside a request state is ignored.
- All outputs are Moore-decoded from state plus latched ir. The exception is the handshake-completion strobes (ir_mux, pcen), which are qualified by mem_ready in the same cycle.

Optional Feature:
Macro: CR16_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE sets illegal = 1 and goes to HALT. HALT holds, with all strobes 0, until reset.
- Undefined: illegal is tied to 0; an illegal opcode executes as NOP (DECODE -> FETCH, no writes).

Test Plan:
- ADD: reset, fetch ir = 16'h0152 with mem_ready on 1st cycle -> FETCH(ir_mux = 1, pcen = 1), DECODE, EXEC_R(regwrt = 1, OP = 8'h05), FETCH; 3 cycles total.
- LOAD with wait states: ir = 16'h4302, mem_ready low 3 cycles in MEM_RD -> mem_req = 1, mem_we = 0 held 4 cycles; LOAD_WB has regwrt = 1, memtoreg = 1.
- Branches: ir = 16'hC005 (BEQ) with zero = 1 -> branch = 1, pc_mux = 1. Same ir with zero = 0 -> branch = 0, back to FETCH.
- JAL: ir = 16'h4E84 -> JUMP asserts jal = 1, jump = 1, regwrt = 1 in one cycle.
- Memory timeout: mem_ready held 0 in FETCH for 20 cycles -> err_timeout single pulse at cycle 15, mem_req stays 1. Reset at cycle 18 -> mem_req = 0 next cycle, state_dbg = 0.
- Illegal opcode: ir = 16'h7000 -> with macro, illegal = 1 and state_dbg = 15 held until reset; without macro, DECODE -> FETCH with no regwrt/mem_req.

Source files
------------

// File: rtl/cr16_mc_controller.sv
`default_nettype none
// ============================================================================
// cr16_mc_controller : multicycle fetch/decode/execute control FSM for CR16.
// Optional: CR16_CTRL_ILLEGAL_TRAP_EN traps illegal opcodes into HALT.
// Rev 1.0
// ============================================================================
module cr16_mc_controller #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic [4:0]  flag,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_mux,
    output logic        pcen,
    output logic        branch,
    output logic        jump,
    output logic        jal,
    output logic        regwrt,
    output logic        memtoreg,
    output logic        im_mux,
    output logic        pc_mux,
    output logic [1:0]  alusrcb,
    output logic [7:0]  OP,
    output logic [3:0]  state_dbg,
    output logic        err_timeout,
    output logic        illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        LOAD_WB  = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        HALT     = 4'd15
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     state, next_state;
    logic [3:0] wait_cnt;
    logic [3:0] opcode, cond, ext;
    logic       cond_true, is_imm_op, req_state;
    logic       unused_bits;

    assign opcode      = ir[15:12];
    assign cond        = ir[11:8];
    assign ext         = ir[7:4];
    assign unused_bits = &{flag[4:2], flag[0], ir[3:0]};

    // N lives in flag[1]; Z comes from the dedicated zero input
    always_comb begin
        case (cond)
            4'b0000: cond_true = zero;
            4'b0001: cond_true = !zero;
            4'b0110: cond_true = flag[1];
            4'b0111: cond_true = !flag[1];
            4'b1100: cond_true = !flag[1] && !zero;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b1001, 4'b1011, 4'b1101, 4'b1111: is_imm_op = 1'b1;
            default:                            is_imm_op = 1'b0;
        endcase
    end

    assign req_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_mux     = 1'b0;
        pcen       = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jal        = 1'b0;
        regwrt     = 1'b0;
        memtoreg   = 1'b0;
        im_mux     = 1'b0;
        pc_mux     = 1'b0;
        alusrcb    = 2'b00;
        OP         = 8'h00;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_mux     = 1'b1;
                    pcen       = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (opcode == 4'b0000)
                    next_state = EXEC_R;
                else if (is_imm_op)
                    next_state = EXEC_I;
                else if (opcode == 4'b0100 && (ext == 4'b0000 || ext == 4'b0100))
                    next_state = MEM_ADDR;
                else if (opcode == 4'b0100 && (ext == 4'b1100 || ext == 4'b1000))
                    next_state = JUMP;
                else if (opcode == 4'b1100)
                    next_state = BRANCH;
                else
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = FETCH;
`endif
            end
            EXEC_R: begin
                regwrt     = (ext != 4'b1011);
                OP         = {opcode, ext};
                next_state = FETCH;
            end
            EXEC_I: begin
                im_mux     = 1'b1;
                regwrt     = (opcode != 4'b1011);
                OP         = {4'b0000, opcode};
                case (opcode)
                    4'b0101, 4'b1001, 4'b1011: alusrcb = 2'b01;
                    4'b1111:                   alusrcb = 2'b11;
                    default:                   alusrcb = 2'b10;
                endcase
                next_state = FETCH;
            end
            MEM_ADDR: next_state = (ext == 4'b0100) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = LOAD_WB;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            LOAD_WB: begin
                regwrt     = 1'b1;
                memtoreg   = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                if (cond_true) begin
                    branch  = 1'b1;
                    pc_mux  = 1'b1;
                    im_mux  = 1'b1;
                    alusrcb = 2'b01;
                end
                next_state = FETCH;
            end
            JUMP: begin
                if (ext == 4'b1000) begin
                    jal    = 1'b1;
                    regwrt = 1'b1;
                    jump   = 1'b1;
                end else begin
                    jump = cond_true;
                end
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
        // Reset silences every strobe immediately so an abandoned request drops
        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ir_mux   = 1'b0;
            pcen     = 1'b0;
            branch   = 1'b0;
            jump     = 1'b0;
            jal      = 1'b0;
            regwrt   = 1'b0;
            memtoreg = 1'b0;
            im_mux   = 1'b0;
            pc_mux   = 1'b0;
            alusrcb  = 2'b00;
            OP       = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !req_state || mem_ready || next_state != state)
            wait_cnt <= 4'd0;
        else if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Fires during the wait cycle that brings the counter to its ceiling
    assign err_timeout = !reset && req_state && !mem_ready && (wait_cnt == WAIT_MAX - 4'd1);
    assign state_dbg   = reset ? 4'd0 : state;

`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    assign illegal = !reset && (state == HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr16_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_cr16_mc_controller : table-driven directed bench for the CR16 control FSM.
// Rev 1.0
// ============================================================================
module tb_cr16_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic [4:0]  flag = 5'b00000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_mux, pcen, branch, jump, jal, regwrt;
    logic        memtoreg, im_mux, pc_mux, err_timeout, illegal;
    logic [1:0]  alusrcb;
    logic [7:0]  OP;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    cr16_mc_controller #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .ir(ir), .flag(flag), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_mux(ir_mux), .pcen(pcen), .branch(branch), .jump(jump), .jal(jal),
        .regwrt(regwrt), .memtoreg(memtoreg), .im_mux(im_mux), .pc_mux(pc_mux),
        .alusrcb(alusrcb), .OP(OP), .state_dbg(state_dbg),
        .err_timeout(err_timeout), .illegal(illegal)
    );

    // Strobe groups: {req,we,ir_mux,pcen, branch,jump,jal, regwrt,memtoreg, im_mux,pc_mux}
    localparam logic [10:0] S_NONE  = 11'b0000_000_00_00;
    localparam logic [10:0] S_FREQ  = 11'b1000_000_00_00;
    localparam logic [10:0] S_FDONE = 11'b1011_000_00_00;
    localparam logic [10:0] S_WR    = 11'b1100_000_00_00;
    localparam logic [10:0] S_RW    = 11'b0000_000_10_00;
    localparam logic [10:0] S_LWB   = 11'b0000_000_11_00;
    localparam logic [10:0] S_RWI   = 11'b0000_000_10_10;
    localparam logic [10:0] S_IMM   = 11'b0000_000_00_10;
    localparam logic [10:0] S_BR    = 11'b0000_100_00_11;
    localparam logic [10:0] S_JAL   = 11'b0000_011_10_00;
    localparam logic [10:0] S_JMP   = 11'b0000_010_00_00;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] ir;
        logic [4:0]  flag;
        logic        zero;
        logic        rdy;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [26:0] actual = {state_dbg, mem_req, mem_we, ir_mux, pcen, branch, jump, jal,
                          regwrt, memtoreg, im_mux, pc_mux, alusrcb, OP, illegal, err_timeout};

    function automatic logic [26:0] o(input logic [3:0] st, input logic [10:0] str,
                                      input logic [1:0] sb, input logic [7:0] op,
                                      input logic ill, input logic tmo);
        return {st, str, sb, op, ill, tmo};
    endfunction

    task automatic add(input string nm, input logic r, input logic [15:0] i,
                       input logic [4:0] f, input logic z, input logic rd,
                       input logic [26:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.ir = i; v.flag = f; v.zero = z; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    // Fetch with immediate ready, decode, then one execute-stage cycle
    task automatic add_instr(input string nm, input logic [15:0] i, input logic [4:0] f,
                             input logic z, input logic [26:0] e_exec);
        add({nm, "_fetch"}, 1'b0, i, f, z, 1'b1, o(4'd0, S_FDONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add({nm, "_dec"},   1'b0, i, f, z, 1'b0, o(4'd1, S_NONE,  2'd0, 8'h00, 1'b0, 1'b0));
        add({nm, "_exec"},  1'b0, i, f, z, 1'b0, e_exec);
    endtask

    task automatic step(input logic r, input logic [15:0] i, input logic [4:0] f,
                        input logic z, input logic rd);
        @(negedge clk);
        reset = r; ir = i; flag = f; zero = z; mem_ready = rd;
        #1;
    endtask

    task automatic check(input string nm, input logic [26:0] e);
        n_tests++;
        if (actual !== e) begin
            n_fail++;
            $display("FAIL %s: got %h (state %0d) expected %h", nm, actual, state_dbg, e);
        end
    endtask

    initial begin
        add("reset", 1'b1, 16'h0152, 5'd0, 1'b0, 1'b0, o(4'd0, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("add", 16'h0152, 5'd0, 1'b0, o(4'd2, S_RW, 2'd0, 8'h05, 1'b0, 1'b0));
        // LOAD: one fetch wait, ready ignored in DECODE, three wait states in MEM_RD
        add("ld_fwait", 1'b0, 16'h4302, 5'd0, 1'b0, 1'b0, o(4'd0, S_FREQ,  2'd0, 8'h00, 1'b0, 1'b0));
        add("ld_fetch", 1'b0, 16'h4302, 5'd0, 1'b0, 1'b1, o(4'd0, S_FDONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add("ld_dec",   1'b0, 16'h4302, 5'd0, 1'b0, 1'b1, o(4'd1, S_NONE,  2'd0, 8'h00, 1'b0, 1'b0));
        add("ld_addr",  1'b0, 16'h4302, 5'd0, 1'b0, 1'b0, o(4'd4, S_NONE,  2'd0, 8'h00, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            add("ld_rd_wait", 1'b0, 16'h4302, 5'd0, 1'b0, 1'b0, o(4'd5, S_FREQ, 2'd0, 8'h00, 1'b0, 1'b0));
        add("ld_rd",    1'b0, 16'h4302, 5'd0, 1'b0, 1'b1, o(4'd5, S_FREQ,  2'd0, 8'h00, 1'b0, 1'b0));
        add("ld_wb",    1'b0, 16'h4302, 5'd0, 1'b0, 1'b0, o(4'd7, S_LWB,   2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("beq_taken", 16'hC005, 5'd0, 1'b1, o(4'd8, S_BR,   2'd1, 8'h00, 1'b0, 1'b0));
        add_instr("beq_not",   16'hC005, 5'd0, 1'b0, o(4'd8, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("jal",       16'h4E84, 5'd0, 1'b0, o(4'd9, S_JAL,  2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("stor", 16'h4142, 5'd0, 1'b0, o(4'd4, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add("stor_wr", 1'b0, 16'h4142, 5'd0, 1'b0, 1'b1, o(4'd6, S_WR, 2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("addi", 16'h5105, 5'd0, 1'b0, o(4'd3, S_RWI, 2'd1, 8'h05, 1'b0, 1'b0));
        add_instr("andi", 16'h1105, 5'd0, 1'b0, o(4'd3, S_RWI, 2'd2, 8'h01, 1'b0, 1'b0));
        add_instr("cmpi", 16'hB105, 5'd0, 1'b0, o(4'd3, S_IMM, 2'd1, 8'h0B, 1'b0, 1'b0));
        add_instr("lui",  16'hF105, 5'd0, 1'b0, o(4'd3, S_RWI, 2'd3, 8'h0F, 1'b0, 1'b0));
        add_instr("cmp",  16'h01B2, 5'd0, 1'b0, o(4'd2, S_NONE, 2'd0, 8'h0B, 1'b0, 1'b0));
        add_instr("juc",  16'h4EC4, 5'd0, 1'b0, o(4'd9, S_JMP, 2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("jgt_t", 16'h46C4, 5'b00010, 1'b0, o(4'd9, S_JMP,  2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("jgt_f", 16'h46C4, 5'b00000, 1'b0, o(4'd9, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
        add_instr("blt",   16'hCC05, 5'b00000, 1'b0, o(4'd8, S_BR,   2'd1, 8'h00, 1'b0, 1'b0));

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].ir, vecs[n].flag, vecs[n].zero, vecs[n].rdy);
            check(vecs[n].name, vecs[n].exp);
        end

        // Fetch stalls for 17 cycles: one timeout pulse on the 15th, request held
        step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
        check("tmo_reset", o(4'd0, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
        for (int c = 1; c <= 17; c++) begin
            step(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
            check($sformatf("tmo_cycle%0d", c), o(4'd0, S_FREQ, 2'd0, 8'h00, 1'b0, (c == 15)));
        end
        step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
        check("tmo_after_reset", o(4'd0, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));

        // Illegal opcode 0111
        step(1'b0, 16'h7000, 5'd0, 1'b0, 1'b1);
        check("ill_fetch", o(4'd0, S_FDONE, 2'd0, 8'h00, 1'b0, 1'b0));
        step(1'b0, 16'h7000, 5'd0, 1'b0, 1'b0);
        check("ill_dec", o(4'd1, S_NONE, 2'd0, 8'h00, 1'b0, 1'b0));
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 16'h7000, 5'd0, 1'b0, 1'b1);
            check("ill_halt", o(4'd15, S_NONE, 2'd0, 8'h00, 1'b1, 1'b0));
        end
`else
        step(1'b0, 16'h7000, 5'd0, 1'b0, 1'b0);
        check("ill_nop", o(4'd0, S_FREQ, 2'd0, 8'h00, 1'b0, 1'b0));
`endif
        step(1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0);
        check("ill_reset", o(4'd0, S_FREQ, 2'd0, 8'h00, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
